// File: rtl/random_word_pkg.sv
// rtl/random_word_pkg.sv - shared types and constants for the random word generator.
package random_word_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'hACE12468;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // Right-shifting Galois step: feedback bit is the LSB shifted out.
  function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/rng_health_rct.sv
// rtl/rng_health_rct.sv - repetition count health test on the raw sample stream.
module rng_health_rct #(
  parameter int REP_LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_valid,
  output logic trip
);

  logic       prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (sample_valid) begin
      prev_d = sample;
      if (cnt_q == 8'd0 || sample != prev_q) begin
        cnt_d = 8'd1;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Trips on the very sample that reaches the limit, so the caller can react next cycle.
  assign trip = sample_valid && (cnt_d == 8'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/random_word_gen.sv
// rtl/random_word_gen.sv - debiased, LFSR-whitened 32-bit random word source with health test.
module random_word_gen
  import random_word_pkg::*;
#(
  parameter int REP_LIMIT   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              noise_in,
  input  logic              sample_en,
  input  logic              rd_ack,
  output logic [WORD_W-1:0] random_export,
  output logic              random_valid,
  output logic              health_fail
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   sync_ext;
  logic                   sync_bit;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   export_q, export_d;
  logic                valid_q, valid_d;
  logic                fail_q, fail_d;
  logic [WORD_W-1:0]   lfsr_q, lfsr_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                pair_full_q, pair_full_d;
  logic                pair_first_q, pair_first_d;

  logic                bit_ok;
  logic [WORD_W-1:0]   acc_next;
  logic [WORD_W-1:0]   lfsr_adv;
  logic                rct_valid;
  logic                trip;

  assign sync_ext = {sync_q, noise_in};
  assign sync_d   = sync_ext[SYNC_STAGES-1:0];
  assign sync_bit = sync_q[SYNC_STAGES-1];

  assign rct_valid = sample_en && (state_q != ST_FAIL);

  rng_health_rct #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rct (
    .clk          (clk_clk),
    .rst          (reset_reset),
    .sample       (sync_bit),
    .sample_valid (rct_valid),
    .trip         (trip)
  );

  assign acc_next = {acc_q[WORD_W-2:0], pair_first_q};
  assign lfsr_adv = lfsr_next(lfsr_q);

  always_comb begin
    state_d      = state_q;
    export_d     = export_q;
    valid_d      = valid_q;
    fail_d       = fail_q;
    lfsr_d       = lfsr_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    pair_full_d  = pair_full_q;
    pair_first_d = pair_first_q;
    bit_ok       = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (sample_en) begin
          if (!pair_full_q) begin
            pair_full_d  = 1'b1;
            pair_first_d = sync_bit;
          end else begin
            pair_full_d = 1'b0;
            bit_ok      = (pair_first_q != sync_bit);
          end
        end
        if (bit_ok) begin
          acc_d     = acc_next;
          lfsr_d    = lfsr_adv;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
            export_d = acc_next ^ lfsr_adv;
            valid_d  = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (rd_ack) begin
          valid_d     = 1'b0;
          bit_cnt_d   = '0;
          pair_full_d = 1'b0;
          state_d     = ST_FILL;
        end
      end
      default: begin
      end
    endcase

    // A health trip overrides completion and acknowledge in the same cycle.
    if (trip) begin
      state_d  = ST_FAIL;
      fail_d   = 1'b1;
      valid_d  = 1'b0;
      export_d = '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q       <= '0;
      state_q      <= ST_FILL;
      export_q     <= '0;
      valid_q      <= 1'b0;
      fail_q       <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      pair_full_q  <= 1'b0;
      pair_first_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      export_q     <= export_d;
      valid_q      <= valid_d;
      fail_q       <= fail_d;
      lfsr_q       <= lfsr_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      pair_full_q  <= pair_full_d;
      pair_first_q <= pair_first_d;
    end
  end

  assign random_export = export_q;
  assign random_valid  = valid_q;
  assign health_fail   = fail_q;

endmodule

// File: tb/tb_random_word_gen.sv
// tb/tb_random_word_gen.sv - self-checking bench for random_word_gen against a behavioural model.
module tb_random_word_gen;

  localparam int          REP  = 32;
  localparam int          SYNC = 2;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst, noise, se, ack;
  logic [31:0] rexp;
  logic        rvalid, hfail;

  random_word_gen #(.REP_LIMIT(REP), .SYNC_STAGES(SYNC)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .noise_in      (noise),
    .sample_en     (se),
    .rd_ack        (ack),
    .random_export (rexp),
    .random_valid  (rvalid),
    .health_fail   (hfail)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: raw sample history, pairing, collected bits and whitening sequence.
  bit        m_sync[SYNC];
  bit        m_valid, m_fail, m_have_first, m_first, m_prev;
  bit [31:0] m_export, m_word, m_lfsr;
  int        m_nbits, m_run;

  function automatic bit [31:0] lfsr_step(bit [31:0] v);
    if (v % 2 == 1) return (v >> 1) ^ POLY;
    return v >> 1;
  endfunction

  function automatic bit [31:0] lfsr_after(int n);
    bit [31:0] v = SEED;
    for (int k = 0; k < n; k++) v = lfsr_step(v);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = 1'b0;
    m_valid = 0; m_fail = 0; m_have_first = 0; m_first = 0; m_prev = 0;
    m_export = 0; m_word = 0; m_lfsr = SEED; m_nbits = 0; m_run = 0;
  endtask

  task automatic model_step(bit n_in, bit s_en, bit a_in);
    bit s;
    bit smp;
    bit tripped;
    s = m_sync[SYNC-1];
    smp = s_en && !m_fail;
    tripped = 0;
    if (smp) begin
      if (m_run == 0 || s != m_prev) m_run = 1;
      else m_run = m_run + 1;
      m_prev = s;
      tripped = (m_run == REP);
    end
    if (tripped) begin
      m_fail = 1; m_valid = 0; m_export = 0;
    end else if (!m_fail) begin
      if (m_valid) begin
        if (a_in) begin
          m_valid = 0; m_nbits = 0; m_have_first = 0;
        end
      end else if (smp) begin
        if (!m_have_first) begin
          m_have_first = 1; m_first = s;
        end else begin
          m_have_first = 0;
          if (m_first != s) begin
            m_word = (m_word << 1) | 32'(m_first);
            m_lfsr = lfsr_step(m_lfsr);
            m_nbits = m_nbits + 1;
            if (m_nbits == 32) begin
              m_export = m_word ^ m_lfsr;
              m_valid = 1;
              m_nbits = 0;
            end
          end
        end
      end
    end
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = n_in;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit n_in, bit s_en, bit a_in);
    rst = r; noise = n_in; se = s_en; ack = a_in;
    @(posedge clk);
    if (r) model_reset();
    else model_step(n_in, s_en, a_in);
    #1;
    chk("model_export", rexp, m_export);
    chk("model_valid", 32'(rvalid), 32'(m_valid));
    chk("model_fail", 32'(hfail), 32'(m_fail));
  endtask

  function automatic bit pat(int kind, int i);
    case (kind)
      0:       return (i % 2) == 0;
      1:       return (i % 2) == 1;
      2:       return 1'b1;
      3:       return ((i / 2) % 2) == 1;
      default: return 1'($urandom & 1);
    endcase
  endfunction

  // Samples lag noise_in by SYNC cycles, so sampling starts SYNC cycles late.
  task automatic run_pattern(int kind, int n, bit chk_pre);
    for (int i = 0; i < n + SYNC; i++) begin
      cyc(1'b0, (i < n) ? pat(kind, i) : 1'b0, i >= SYNC, 1'b0);
      if (chk_pre && i == n) begin
        chk("pre_last_valid", 32'(rvalid), 32'd0);
        chk("pre_last_fail", 32'(hfail), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1; noise = 0; se = 0; ack = 0;
    model_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_export", rexp, 32'd0);
    chk("reset_valid", 32'(rvalid), 32'd0);
    chk("reset_fail", 32'(hfail), 32'd0);

    // 32 "10" pairs: all-ones accumulator
    run_pattern(0, 64, 1);
    chk("w10_valid", 32'(rvalid), 32'd1);
    chk("w10_word", rexp, ~lfsr_after(32));

    // held word ignores samples for 100 cycles
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1'($urandom & 1), 1, 0);
      chk("hold_stable", rexp, ~lfsr_after(32));
    end
    cyc(0, 0, 0, 1);
    chk("ack_clears_valid", 32'(rvalid), 32'd0);
    chk("ack_keeps_export", rexp, ~lfsr_after(32));
    run_pattern(0, 64, 1);
    chk("second_valid", 32'(rvalid), 32'd1);
    chk("second_word", rexp, ~lfsr_after(64));

    // 32 "01" pairs: zero accumulator exposes the LFSR
    cyc(1, 0, 0, 0);
    run_pattern(1, 64, 1);
    chk("w01_valid", 32'(rvalid), 32'd1);
    chk("w01_word", rexp, lfsr_after(32));
    cyc(0, 0, 0, 1);

    // 0,0,1,1 repeating: no debiased bits, no health trip
    cyc(1, 0, 0, 0);
    run_pattern(3, 200, 0);
    chk("0011_valid", 32'(rvalid), 32'd0);
    chk("0011_fail", 32'(hfail), 32'd0);

    // reset mid-word discards partial bits and reseeds
    cyc(1, 0, 0, 0);
    run_pattern(0, 40, 0);
    chk("partial_valid", 32'(rvalid), 32'd0);
    cyc(1, 0, 0, 0);
    chk("midreset_export", rexp, 32'd0);
    chk("midreset_valid", 32'(rvalid), 32'd0);
    run_pattern(0, 64, 1);
    chk("after_midreset_word", rexp, ~lfsr_after(32));

    // stuck-at-one source trips the health test
    cyc(1, 0, 0, 0);
    run_pattern(2, 32, 1);
    chk("stuck_fail", 32'(hfail), 32'd1);
    chk("stuck_valid", 32'(rvalid), 32'd0);
    chk("stuck_export", rexp, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'($urandom & 1), 1, 1);
      chk("fail_sticky", 32'(hfail), 32'd1);
      chk("fail_no_valid", 32'(rvalid), 32'd0);
    end

    // trip coinciding with rd_ack while a word is held
    cyc(1, 0, 0, 0);
    run_pattern(0, 64, 0);
    for (int i = 0; i < 32 + SYNC; i++) begin
      cyc(0, i < 32, i >= SYNC, i == 31 + SYNC);
      if (i == 30 + SYNC) chk("pre_trip_valid", 32'(rvalid), 32'd1);
    end
    chk("ack_trip_fail", 32'(hfail), 32'd1);
    chk("ack_trip_valid", 32'(rvalid), 32'd0);
    chk("ack_trip_export", rexp, 32'd0);

    // randomized traffic against the model
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 500) == 0, 1'($urandom & 1), ($urandom % 3) != 0, ($urandom % 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/random_word_gen.md
RANDOM_WORD_GEN -- requirements
Module: random_word_gen

Interface
REQ-001 SHALL have parameter REP_LIMIT, default 32, meaning the consecutive-identical-sample count that trips the health test (range 2..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on noise_in.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port noise_in, input, 1 bit: raw asynchronous entropy bit (ring-oscillator source).
REQ-006 SHALL have port sample_en, input, 1 bit: strobe that qualifies one synchronized noise sample per high cycle.
REQ-007 SHALL have port rd_ack, input, 1 bit: one-cycle pulse from the consumer releasing the held word.
REQ-008 SHALL have port random_export, output, 32 bits: conditioned random word, wired to the wallet's random PIO input.
REQ-009 SHALL have port random_valid, output, 1 bit: high while random_export holds an unconsumed word.
REQ-010 SHALL have port health_fail, output, 1 bit: sticky health-test failure flag.

Function
REQ-011 SHALL pass noise_in through SYNC_STAGES flops; only the synchronized bit is sampled, and only in cycles with sample_en=1.
REQ-012 SHALL run a repetition count test on every sample in every state except FAIL: count=1 on the first sample and on any change; count+1 on a repeat; trip when count==REP_LIMIT.
REQ-013 SHALL debias samples von Neumann style: samples pair as (first, second); unequal pair emits bit = first; equal pair emits nothing; pairing restarts on every entry to FILL.
REQ-014 SHALL shift each debiased bit into a 32-bit accumulator at the LSB (shift left) and count the bits, 0..31.
REQ-015 SHALL advance a 32-bit Galois LFSR (poly 0x80200003, seed 0xACE12468) exactly once per debiased bit accepted in FILL.
REQ-016 SHALL implement states FILL, HOLD and FAIL.
REQ-017 SHALL, in FILL on acceptance of the 32nd bit, load random_export = accumulator_with_new_bit XOR post-advance LFSR, set random_valid=1 and enter HOLD, all visible the next cycle.
REQ-018 SHALL, in HOLD, hold random_export stable, accumulate nothing and keep the LFSR frozen; rd_ack=1 clears random_valid and clears the bit count the next cycle, and returns to FILL.
REQ-019 SHALL ignore rd_ack in FILL and in FAIL.
REQ-020 SHALL, on a health trip in any state, enter FAIL the next cycle: health_fail=1, random_valid=0, random_export=0; FAIL exits only on reset.
REQ-021 SHALL give the health trip priority when it coincides with rd_ack or with the 32nd-bit completion.
REQ-022 SHALL keep random_export at the previous word while FILL collects the next word.

Reset
REQ-023 SHALL, with reset_reset=1 at a clk_clk edge, set: state=FILL, random_export=0, random_valid=0, health_fail=0, LFSR=seed, bit count=0, repetition count=0, pair state empty, synchronizer flops=0.
REQ-024 SHALL discard a partial word on a reset taken mid-FILL; the next word needs a full 32 fresh bits.

Structure
REQ-025 SHALL take the state enum, WORD_W=32, LFSR_POLY and LFSR_SEED from shared package random_word_pkg.
REQ-026 SHALL implement the repetition count test as sub-module rng_health_rct (in: sample, sample_valid; out: trip).

Verification
REQ-027 SHALL cover: sample_en=1 continuously, 32 pairs "10" -> random_valid after the 64th sample, random_export = ~LFSR after 32 steps from 0xACE12468.
REQ-028 SHALL cover: 32 pairs "01" -> random_export = LFSR value after 32 steps (accumulator 0x00000000).
REQ-029 SHALL cover: noise_in held at 1 for 32 samples -> health_fail=1 the cycle after the 32nd sample, random_valid=0, no word ever issued; rd_ack has no effect.
REQ-030 SHALL cover: repeating samples 0,0,1,1 for 200 samples -> no debiased bits, random_valid stays 0, health_fail stays 0.
REQ-031 SHALL cover: word held with rd_ack=0 for 100 cycles, export stable; rd_ack pulse -> random_valid=0 next cycle; next word arrives after 64 more "10" samples.
REQ-032 SHALL cover: reset after 20 accepted bits -> all outputs 0, LFSR reseeded; rd_ack coincident with a health trip -> FAIL, health_fail=1.
